// File: rtl/network_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | network_pkg                                                                |
// | Shared sizes and the constant weight function for the 2-8-6-12 network.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
package network_pkg;
    localparam int T  = 16;
    localparam int N0 = 2;
    localparam int M1 = 8;
    localparam int M2 = 6;
    localparam int M3 = 12;
    localparam int P1 = 1;
    localparam int P2 = 2;
    localparam int P3 = 4;

    // Wk[m][n] spans -2..2; k is the 1-based layer index.
    function automatic int weight(input int k, input int m, input int n);
        return ((m + 2 * n + k) % 5) - 2;
    endfunction
endpackage
`default_nettype wire

// File: rtl/fc_layer.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | fc_layer                                                                   |
// | One ReLU layer: P rows per group, one input column per cycle, wrapping.    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module fc_layer #(
    parameter int N = 2,
    parameter int M = 8,
    parameter int P = 1,
    parameter int K = 1,
    parameter int T = 16
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           in_valid,
    input  logic [N*T-1:0] in_data,
    output logic           in_take,
    output logic           out_valid,
    input  logic           out_take,
    output logic [M*T-1:0] out_data
);
    localparam int c_G  = M / P;
    localparam int c_CW = (N > 1) ? $clog2(N) : 1;
    localparam int c_GW = (c_G > 1) ? $clog2(c_G) : 1;
    localparam logic [c_CW-1:0] c_COL_LAST = c_CW'(N - 1);
    localparam logic [c_GW-1:0] c_GRP_LAST = c_GW'(c_G - 1);

    logic signed [T-1:0] r_x   [N];
    logic signed [T-1:0] r_acc [P];
    logic signed [T-1:0] w_sum [P];
    logic [c_CW-1:0]     r_col;
    logic [c_GW-1:0]     r_grp;
    logic                r_busy;
    logic                r_full;
    logic signed [T-1:0] w_xn;

    // A new vector is taken only once the previous result has been handed on.
    assign in_take   = in_valid && !r_busy && !r_full;
    assign out_valid = r_full;
    assign w_xn      = r_x[r_col];

    generate
        for (genvar p = 0; p < P; p++) begin : g_mac
            logic signed [T-1:0] w_wt;
            logic signed [T-1:0] w_prod;
            assign w_wt     = T'(network_pkg::weight(K, int'(r_grp) * P + p, int'(r_col)));
            assign w_prod   = w_wt * w_xn;
            assign w_sum[p] = r_acc[p] + w_prod;
        end
    endgenerate

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_busy <= 1'b0;
            r_full <= 1'b0;
            r_col  <= '0;
            r_grp  <= '0;
            for (int n = 0; n < N; n++) r_x[n] <= '0;
            for (int p = 0; p < P; p++) r_acc[p] <= '0;
        end else begin
            if (out_take) r_full <= 1'b0;
            if (in_take) begin
                r_busy <= 1'b1;
                for (int n = 0; n < N; n++) r_x[n] <= in_data[n*T +: T];
            end else if (r_busy) begin
                for (int p = 0; p < P; p++) r_acc[p] <= (r_col == c_COL_LAST) ? '0 : w_sum[p];
                if (r_col == c_COL_LAST) begin
                    r_col <= '0;
                    if (r_grp == c_GRP_LAST) begin
                        r_grp  <= '0;
                        r_busy <= 1'b0;
                        r_full <= 1'b1;
                    end else begin
                        r_grp <= r_grp + 1'b1;
                    end
                end else begin
                    r_col <= r_col + 1'b1;
                end
            end
        end
    end

    generate
        for (genvar m = 0; m < M; m++) begin : g_row
            localparam logic [c_GW-1:0] c_ROW_GRP = c_GW'(m / P);
            logic signed [T-1:0] r_y;
            always_ff @(posedge clk or posedge reset) begin
                if (reset)
                    r_y <= '0;
                else if (r_busy && (r_col == c_COL_LAST) && (r_grp == c_ROW_GRP))
                    r_y <= w_sum[m % P][T-1] ? '0 : w_sum[m % P];
            end
            assign out_data[m*T +: T] = r_y;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/network_2_8_6_12_7_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | network_2_8_6_12_7_16                                                      |
// | Streaming 2->8->6->12 ReLU network: input buffer, three layers, serializer.|
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module network_2_8_6_12_7_16
    import network_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         s_valid,
    input  logic         m_ready,
    input  logic [T-1:0] data_in,
    output logic         m_valid,
    output logic         s_ready,
    output logic [T-1:0] data_out
);
    localparam logic [1:0] c_IN_FULL  = 2'(N0);
    localparam logic [3:0] c_OB_WORDS = 4'(M3);

    logic            r_alive;
    logic [1:0]      r_in_cnt;
    logic [N0*T-1:0] r_in_data;
    logic [3:0]      r_ob_cnt;
    logic [M3*T-1:0] r_ob;
    logic            w_in_full;
    logic            w_ob_load;
    logic            w_l1_take, w_l1_valid;
    logic            w_l2_take, w_l2_valid;
    logic            w_l3_take, w_l3_valid;
    logic [M1*T-1:0] w_h1;
    logic [M2*T-1:0] w_h2;
    logic [M3*T-1:0] w_h3;

    assign w_in_full = (r_in_cnt == c_IN_FULL);
    assign s_ready   = r_alive && !w_in_full;
    assign m_valid   = (r_ob_cnt != '0);
    assign data_out  = r_ob[T-1:0];
    assign w_ob_load = w_l3_valid && !m_valid;

    // Words shift in from the top so x[0] ends up in the lowest slot.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alive   <= 1'b0;
            r_in_cnt  <= '0;
            r_in_data <= '0;
        end else begin
            r_alive <= 1'b1;
            if (w_l1_take) begin
                r_in_cnt <= '0;
            end else if (s_valid && s_ready) begin
                r_in_data <= {data_in, r_in_data[N0*T-1:T]};
                r_in_cnt  <= r_in_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ob_cnt <= '0;
            r_ob     <= '0;
        end else if (w_ob_load) begin
            r_ob     <= w_h3;
            r_ob_cnt <= c_OB_WORDS;
        end else if (m_valid && m_ready) begin
            r_ob     <= {{T{1'b0}}, r_ob[M3*T-1:T]};
            r_ob_cnt <= r_ob_cnt - 1'b1;
        end
    end

    fc_layer #(.N(N0), .M(M1), .P(P1), .K(1), .T(T)) u_l1 (
        .clk(clk), .reset(reset),
        .in_valid(w_in_full), .in_data(r_in_data), .in_take(w_l1_take),
        .out_valid(w_l1_valid), .out_take(w_l2_take), .out_data(w_h1)
    );

    fc_layer #(.N(M1), .M(M2), .P(P2), .K(2), .T(T)) u_l2 (
        .clk(clk), .reset(reset),
        .in_valid(w_l1_valid), .in_data(w_h1), .in_take(w_l2_take),
        .out_valid(w_l2_valid), .out_take(w_l3_take), .out_data(w_h2)
    );

    fc_layer #(.N(M2), .M(M3), .P(P3), .K(3), .T(T)) u_l3 (
        .clk(clk), .reset(reset),
        .in_valid(w_l2_valid), .in_data(w_h2), .in_take(w_l3_take),
        .out_valid(w_l3_valid), .out_take(w_ob_load), .out_data(w_h3)
    );
endmodule
`default_nettype wire

// File: tb/tb_network_2_8_6_12_7_16.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | tb_network_2_8_6_12_7_16                                                   |
// | Scoreboard bench: driver queues expected words, monitor pops on transfer.  |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module tb_network_2_8_6_12_7_16;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        s_valid = 1'b0;
    logic        m_ready = 1'b0;
    logic [15:0] data_in = 16'd0;
    logic        m_valid;
    logic        s_ready;
    logic [15:0] data_out;

    int          checks = 0;
    int          errors = 0;
    logic [15:0] exp_q [$];
    int          rdy_mode = 0;   // 0 ready, 1 random, 2 stalled
    int          in_gap = 0;
    bit          prev_hold = 1'b0;
    logic [15:0] prev_data = 16'd0;

    int y_00 [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    int y_10 [12] = '{0, 0, 0, 4, 10, 0, 0, 0, 4, 10, 0, 0};
    int y_20 [12] = '{0, 0, 0, 8, 20, 0, 0, 0, 8, 20, 0, 0};
    int y_01 [12] = '{14, 32, 0, 0, 0, 14, 32, 0, 0, 0, 14, 32};

    network_2_8_6_12_7_16 dut (
        .clk(clk), .reset(reset), .s_valid(s_valid), .m_ready(m_ready),
        .data_in(data_in), .m_valid(m_valid), .s_ready(s_ready), .data_out(data_out)
    );

    always #5 clk = ~clk;

    function automatic logic [191:0] pk(input int v [12]);
        logic [191:0] r;
        r = '0;
        for (int m = 0; m < 12; m++) r[m*16 +: 16] = 16'(v[m]);
        return r;
    endfunction

    function automatic int wt(input int k, input int m, input int n);
        return ((m + 2 * n + k) % 5) - 2;
    endfunction

    function automatic logic [191:0] model(input logic [15:0] x0, input logic [15:0] x1);
        logic [15:0]  a [12];
        logic [15:0]  b [12];
        int           sz [4];
        logic [15:0]  acc;
        int           p;
        logic [191:0] r;
        sz = '{2, 8, 6, 12};
        for (int i = 0; i < 12; i++) begin a[i] = 16'd0; b[i] = 16'd0; end
        a[0] = x0;
        a[1] = x1;
        for (int k = 1; k <= 3; k++) begin
            for (int m = 0; m < sz[k]; m++) begin
                acc = 16'd0;
                for (int n = 0; n < sz[k-1]; n++) begin
                    p   = wt(k, m, n) * int'($signed(a[n]));
                    acc = acc + p[15:0];
                end
                b[m] = acc[15] ? 16'd0 : acc;
            end
            for (int i = 0; i < 12; i++) a[i] = b[i];
        end
        for (int m = 0; m < 12; m++) r[m*16 +: 16] = a[m];
        return r;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0d (0x%h), expected %0d (0x%h)", name, $signed(act), act, $signed(req), req);
        end
    endtask

    initial forever begin
        @(posedge clk);
        #1;
        case (rdy_mode)
            0:       m_ready = 1'b1;
            1:       m_ready = 1'($urandom_range(0, 1));
            default: m_ready = 1'b0;
        endcase
    end

    // Monitor: a word counts as transferred when valid and ready are both high mid-cycle.
    initial forever begin
        @(negedge clk);
        if (reset) begin
            prev_hold = 1'b0;
        end else begin
            if (prev_hold) begin
                check("hold_m_valid", 16'(m_valid), 16'd1);
                check("hold_data_out", data_out, prev_data);
            end
            if (m_valid && m_ready) begin
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_output: got %0d, expected no output", $signed(data_out));
                end else begin
                    check("y", data_out, exp_q.pop_front());
                end
            end
            prev_hold = m_valid && !m_ready;
            prev_data = data_out;
        end
    end

    task automatic send_word(input logic [15:0] w);
        int  t;
        bit  acc;
        t = 0;
        if (in_gap > 0) repeat ($urandom_range(0, in_gap)) begin @(posedge clk); #1; end
        s_valid = 1'b1;
        data_in = w;
        forever begin
            @(negedge clk);
            acc = s_ready;
            @(posedge clk);
            #1;
            if (acc) break;
            t++;
            if (t > 2000) begin
                checks++;
                errors++;
                $display("FAIL send_timeout: s_ready 0 for %0d cycles, expected 1", t);
                break;
            end
        end
        s_valid = 1'b0;
        data_in = 16'd0;
    endtask

    task automatic send_vec(input logic [15:0] x0, input logic [15:0] x1, input logic [191:0] y);
        for (int m = 0; m < 12; m++) exp_q.push_back(y[m*16 +: 16]);
        send_word(x0);
        send_word(x1);
    endtask

    task automatic wait_drain(input int limit);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < limit) begin @(posedge clk); #1; t++; end
        if (exp_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain_timeout: %0d outputs pending, expected 0", exp_q.size());
            exp_q.delete();
        end
        repeat (2) begin @(posedge clk); #1; end
        check("idle_m_valid", 16'(m_valid), 16'd0);
    endtask

    initial begin
        int t;
        logic [15:0] x0, x1;

        repeat (3) begin @(posedge clk); #1; end
        check("rst_m_valid", 16'(m_valid), 16'd0);
        check("rst_s_ready", 16'(s_ready), 16'd0);
        check("rst_data_out", data_out, 16'd0);
        reset = 1'b0;
        @(posedge clk);
        #1;
        check("s_ready_after_rst", 16'(s_ready), 16'd1);

        // Directed vectors, full throughput.
        send_vec(16'd0,     16'd0, pk(y_00));
        send_vec(16'd1,     16'd0, pk(y_10));
        send_vec(16'd16384, 16'd0, pk(y_00));
        send_vec(16'd0,     16'd1, pk(y_01));
        send_vec(16'd2,     16'd0, pk(y_20));
        wait_drain(1000);

        // Downstream stalled: every stage fills, then the input side must close.
        rdy_mode = 2;
        repeat (2) begin @(posedge clk); #1; end
        send_vec(16'd0,     16'd1, pk(y_01));
        send_vec(16'd1,     16'd0, pk(y_10));
        send_vec(16'd2,     16'd0, pk(y_20));
        send_vec(16'd0,     16'd1, pk(y_01));
        send_vec(16'd16384, 16'd0, pk(y_00));
        repeat (500) begin @(posedge clk); #1; end
        check("bp_s_ready", 16'(s_ready), 16'd0);
        check("bp_m_valid", 16'(m_valid), 16'd1);
        check("bp_data_out", data_out, 16'd14);
        rdy_mode = 0;
        wait_drain(2000);

        // Random data with random gaps and random stalls.
        rdy_mode = 1;
        for (int i = 0; i < 150; i++) begin
            in_gap = (i < 100) ? 2 : 0;
            if (i % 3 == 0) begin
                x0 = 16'($urandom);
                x1 = 16'($urandom);
            end else begin
                x0 = 16'($urandom_range(0, 80)) - 16'd40;
                x1 = 16'($urandom_range(0, 80)) - 16'd40;
            end
            send_vec(x0, x1, model(x0, x1));
        end
        in_gap = 0;
        rdy_mode = 0;
        wait_drain(3000);

        // Reset with half an input vector buffered.
        send_word(16'd1);
        repeat (3) begin @(posedge clk); #1; end
        #2 reset = 1'b1;
        #1;
        check("rst_half_s_ready", 16'(s_ready), 16'd0);
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        send_vec(16'd1, 16'd0, pk(y_10));
        wait_drain(500);

        // Reset while an output vector is being drained.
        rdy_mode = 1;
        send_vec(16'd0, 16'd1, pk(y_01));
        t = 0;
        while (exp_q.size() > 6 && t < 1000) begin @(negedge clk); t++; end
        if (exp_q.size() > 6) begin
            checks++;
            errors++;
            $display("FAIL mid_output_timeout: %0d outputs pending, expected at most 6", exp_q.size());
        end
        #2 reset = 1'b1;
        #1;
        check("rst_mid_m_valid", 16'(m_valid), 16'd0);
        check("rst_mid_data_out", data_out, 16'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        rdy_mode = 0;
        @(posedge clk);
        #1;
        check("s_ready_after_rst2", 16'(s_ready), 16'd1);
        send_vec(16'd1, 16'd0, pk(y_10));
        wait_drain(500);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, expected completion");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
